// File: rtl/rt_shift_ctrl_mu.sv
// Racetrack memory unit with shared domain-offset tracking and a built-in shift
// controller: shifts one domain per cycle until the word is aligned, then accesses it.
module rt_shift_ctrl_mu #(
  parameter  int NR  = 4,
  parameter  int NB  = 32,
  parameter  int NP  = 8,
  localparam int NSP = NB / NP,
  localparam int AW  = $clog2(NB) + 1,
  localparam int OW  = (NSP > 1) ? $clog2(NSP) : 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          req_i,
  output logic          ready_o,
  input  logic [1:0]    op_i,
  input  logic [AW-1:0] addr_i,
  input  logic [NR-1:0] wdata_i,
  input  logic          nand_norn_i,
  output logic          valid_o,
  output logic [NR-1:0] rdata_o,
  output logic          err_o,
  output logic          shift_o,
  output logic          shift_dir_o,
  output logic [OW-1:0] offset_o,
  output logic [31:0]   shift_cnt_o,
  output logic [1:0]    dbg_state_o
);

  localparam int            IW    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] NB_L  = AW'(NB);
  localparam logic [AW-1:0] NSP_L = AW'(NSP);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_WM  = 2'b10;
  localparam logic [1:0] OP_LIM = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Handshake: a request is taken on the edge where req_i and ready_o are both high;
  // valid_o is a single-cycle pulse and ready_o is already high in that same cycle.

  state_t        r_state;
  state_t        w_state_next;

  logic [1:0]    r_op;
  logic [AW-1:0] r_addr;
  logic [NR-1:0] r_wdata;
  logic          r_nand;
  logic [OW-1:0] r_offset;
  logic [31:0]   r_shift_cnt;
  logic          r_valid;
  logic          r_err;
  logic [NR-1:0] r_rdata;
  logic [NR-1:0] r_data [NB];
  logic [NR-1:0] r_mask [NB];

  logic          w_accept;
  logic          w_addr_err;
  logic [OW-1:0] w_in_slot;
  logic [OW-1:0] w_tgt_slot;
  logic [OW-1:0] w_offset_next;
  logic          w_dir_up;
  logic [IW-1:0] w_word;

  assign w_accept      = req_i && (r_state == S_IDLE);
  assign w_addr_err    = (addr_i >= NB_L);
  assign w_in_slot     = OW'(addr_i % NSP_L);
  assign w_tgt_slot    = OW'(r_addr % NSP_L);
  assign w_dir_up      = (w_tgt_slot > r_offset);
  assign w_offset_next = w_dir_up ? (r_offset + OW'(1)) : (r_offset - OW'(1));
  assign w_word        = r_addr[IW-1:0];

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_addr_err) begin
          w_state_next = (w_in_slot != r_offset) ? S_SHIFT : S_ACCESS;
        end
      end
      S_SHIFT: begin
        if (w_offset_next == w_tgt_slot) begin
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o     = 1'b0;
    shift_o     = 1'b0;
    shift_dir_o = 1'b0;
    case (r_state)
      S_IDLE:  ready_o = 1'b1;
      S_SHIFT: begin
        shift_o     = 1'b1;
        shift_dir_o = w_dir_up;
      end
      default: ;
    endcase
  end

  // Datapath: request latch, offset/shift counter, storage planes, result registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_op        <= OP_RD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_nand      <= 1'b0;
      r_offset    <= '0;
      r_shift_cnt <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      for (int i = 0; i < NB; i++) begin
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      if (w_accept) begin
        r_op    <= op_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_nand  <= nand_norn_i;
        if (w_addr_err) begin
          r_valid <= 1'b1;
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end

      if (r_state == S_SHIFT) begin
        r_offset <= w_offset_next;
        if (r_shift_cnt != 32'hFFFF_FFFF) begin
          r_shift_cnt <= r_shift_cnt + 32'd1;
        end
      end

      if (r_state == S_ACCESS) begin
        r_valid <= 1'b1;
        case (r_op)
          OP_RD: r_rdata <= r_data[w_word];
          OP_WR: begin
            r_data[w_word] <= r_wdata;
            r_rdata        <= r_wdata;
          end
          OP_WM: begin
            r_mask[w_word] <= r_wdata;
            r_rdata        <= r_wdata;
          end
          OP_LIM: r_rdata <= r_nand ? ~(r_data[w_word] & r_mask[w_word])
                                    : ~(r_data[w_word] | r_mask[w_word]);
          default: r_rdata <= '0;
        endcase
      end
    end
  end

  assign valid_o     = r_valid;
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign offset_o    = r_offset;
  assign shift_cnt_o = r_shift_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rt_shift_ctrl_mu.sv
// Directed bench for rt_shift_ctrl_mu: driver pushes expected {err, rdata} into a
// queue, a negedge monitor pops and compares on every valid_o pulse.
module tb_rt_shift_ctrl_mu;

  localparam int NR = 4;
  localparam int AW = 6;
  localparam int OW = 2;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          req_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [AW-1:0] addr_i = '0;
  logic [NR-1:0] wdata_i = '0;
  logic          nand_norn_i = 1'b0;
  logic          ready_o;
  logic          valid_o;
  logic [NR-1:0] rdata_o;
  logic          err_o;
  logic          shift_o;
  logic          shift_dir_o;
  logic [OW-1:0] offset_o;
  logic [31:0]   shift_cnt_o;
  logic [1:0]    dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NR:0] exp_q[$];

  rt_shift_ctrl_mu #(.NR(4), .NB(32), .NP(8)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (req_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .nand_norn_i (nand_norn_i),
    .valid_o     (valid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .shift_o     (shift_o),
    .shift_dir_o (shift_dir_o),
    .offset_o    (offset_o),
    .shift_cnt_o (shift_cnt_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        logic [NR:0] e;
        e = exp_q.pop_front();
        check("rdata", 32'(rdata_o), 32'(e[NR-1:0]));
        check("err", 32'(err_o), 32'(e[NR]));
      end
    end
  end

  // Driver: issues one request at a negedge, then tracks shifts and latency.
  task automatic do_req(input string name, input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [NR-1:0] wd, input logic nn, input logic [NR-1:0] exp_rd,
                        input logic exp_err, input int exp_d, input logic exp_dir,
                        input logic [OW-1:0] exp_off);
    int   n;
    int   lat;
    int   pulses;
    bit   dir_ok;
    logic [31:0] cnt0;
    n = 0;
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_ready"}, 32'(ready_o), 32'd1);
    cnt0        = shift_cnt_o;
    req_i       = 1'b1;
    op_i        = op;
    addr_i      = addr;
    wdata_i     = wd;
    nand_norn_i = nn;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk_i);
    #1 req_i = 1'b0;
    lat    = 0;
    pulses = 0;
    dir_ok = 1'b1;
    while (lat < 100) begin
      @(negedge clk_i);
      lat++;
      if (shift_o === 1'b1) begin
        pulses++;
        if (shift_dir_o !== exp_dir) dir_ok = 1'b0;
      end
      if (valid_o === 1'b1) break;
    end
    check({name, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'(exp_d + 2));
    check({name, "_pulses"}, 32'(pulses), 32'(exp_d));
    check({name, "_dir_ok"}, 32'(dir_ok), 32'd1);
    check({name, "_offset"}, 32'(offset_o), 32'(exp_off));
    check({name, "_shift_cnt"}, shift_cnt_o, cnt0 + 32'(exp_d));
  endtask

  initial begin
    // Reset
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    check("rst_shift", 32'(shift_o), 32'd0);
    check("rst_dir", 32'(shift_dir_o), 32'd0);
    check("rst_offset", 32'(offset_o), 32'd0);
    check("rst_cnt", shift_cnt_o, 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    //      name        op     addr   wd    nn    exp_rd err d  dir off
    do_req("rd13",     2'b00, 6'd13, 4'h0, 1'b0, 4'h0, 1'b0, 1, 1'b1, 2'd1);
    do_req("wr7",      2'b01, 6'd7,  4'hA, 1'b0, 4'hA, 1'b0, 2, 1'b1, 2'd3);
    do_req("rd3",      2'b00, 6'd3,  4'h0, 1'b0, 4'h0, 1'b0, 0, 1'b0, 2'd3);
    do_req("rd7",      2'b00, 6'd7,  4'h0, 1'b0, 4'hA, 1'b0, 0, 1'b0, 2'd3);
    do_req("wrd5",     2'b01, 6'd5,  4'hC, 1'b0, 4'hC, 1'b0, 2, 1'b0, 2'd1);
    do_req("wrm5",     2'b10, 6'd5,  4'hA, 1'b0, 4'hA, 1'b0, 0, 1'b0, 2'd1);
    do_req("lim_nand", 2'b11, 6'd5,  4'h0, 1'b1, 4'h7, 1'b0, 0, 1'b0, 2'd1);
    do_req("lim_nor",  2'b11, 6'd5,  4'h0, 1'b0, 4'h1, 1'b0, 0, 1'b0, 2'd1);
    do_req("rd31",     2'b00, 6'd31, 4'h0, 1'b0, 4'h0, 1'b0, 2, 1'b1, 2'd3);
    do_req("rd8_down", 2'b00, 6'd8,  4'h0, 1'b0, 4'h0, 1'b0, 3, 1'b0, 2'd0);
    do_req("err40",    2'b01, 6'd40, 4'hF, 1'b0, 4'h0, 1'b1, 0, 1'b0, 2'd0);
    do_req("err37",    2'b10, 6'd37, 4'h0, 1'b0, 4'h0, 1'b1, 0, 1'b0, 2'd0);
    do_req("err32",    2'b00, 6'd32, 4'h0, 1'b0, 4'h0, 1'b1, 0, 1'b0, 2'd0);
    do_req("rd8_keep", 2'b00, 6'd8,  4'h0, 1'b0, 4'h0, 1'b0, 0, 1'b0, 2'd0);
    do_req("lim_keep", 2'b11, 6'd5,  4'h0, 1'b1, 4'h7, 1'b0, 1, 1'b1, 2'd1);
    do_req("rd8_back", 2'b00, 6'd8,  4'h0, 1'b0, 4'h0, 1'b0, 1, 1'b0, 2'd0);

    // Reset during the second shift cycle of a write to word 11 (d=3)
    req_i   = 1'b1;
    op_i    = 2'b01;
    addr_i  = 6'd11;
    wdata_i = 4'hF;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(negedge clk_i);
    check("abort_shift1", 32'(shift_o), 32'd1);
    @(negedge clk_i);
    check("abort_shift2", 32'(shift_o), 32'd1);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    check("abort_offset", 32'(offset_o), 32'd0);
    check("abort_cnt", shift_cnt_o, 32'd0);
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_ready", 32'(ready_o), 32'd1);
    repeat (3) @(negedge clk_i);
    do_req("rd11_after", 2'b00, 6'd11, 4'h0, 1'b0, 4'h0, 1'b0, 3, 1'b1, 2'd3);

    repeat (3) @(negedge clk_i);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rt_shift_ctrl_mu.md
# rt_shift_ctrl_mu

Parametrised racetrack memory unit with a built-in shift controller. It generalises the fixed 32-domain / 8-port / 4-track logic-in-memory array to NR tracks, NB domains and NP access ports. Unlike the fixed array, it tracks the physical domain offset, which is shared by all tracks. For each request it issues one shift pulse per cycle until the addressed word sits under its port, then performs a data read, data write, mask write or LiM (NAND/NOR) read. It sits between the core-side memory interface and the racetrack array model in the testbench memory subsystem.

## Interface
- NR, 4, racetracks = word width in bits
- NB, 32, domains per track = words stored; must be a multiple of NP
- NP, 8, access ports per track; NSP = NB/NP words per port segment
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low
- req_i  in  1  request valid
- ready_o  out  1  controller idle, request accepted when req_i & ready_o
- op_i  in  2  00 read data, 01 write data, 10 write mask, 11 LiM read
- addr_i  in  $clog2(NB)+1  word address
- wdata_i  in  NR  write value (ops 01/10)
- nand_norn_i  in  1  LiM function: 1 NAND, 0 NOR
- valid_o  out  1  one-cycle completion pulse
- rdata_o  out  NR  read result; held until next completion
- err_o  out  1  qualifies valid_o: address out of range
- shift_o  out  1  shift pulse this cycle
- shift_dir_o  out  1  1 = offset increments, 0 = decrements
- offset_o  out  $clog2(NSP) (min 1)  current domain offset, 0..NSP-1
- shift_cnt_o  out  32  total shift pulses since reset, saturating

## Operation
- Storage: data plane D[NB][NR] and mask plane M[NB][NR].
- Word w maps to port p = w / NSP and slot s = w % NSP. The word is aligned when offset == s.
- Tracks are linear, not circular. Offset stays in 0..NSP-1 and never wraps.
- Target distance d = |s − offset|. Direction is 1 when s > offset.
- FSM states: IDLE, SHIFT, ACCESS.
- IDLE (ready_o=1):
  - On acceptance, latch op, addr, wdata and nand_norn.
  - addr ≥ NB: go straight back to IDLE, assert valid_o and err_o, set rdata_o to 0, no shift.
  - Otherwise go to SHIFT if d>0, or to ACCESS if d=0.
- SHIFT (ready_o=0):
  - shift_o=1 and shift_dir_o valid combinationally.
  - On each edge, offset moves by ±1 and shift_cnt_o increments (saturating at 2^32−1).
  - Go to ACCESS on the edge where offset reaches s.
- ACCESS (ready_o=0), one cycle. On its edge:
  - 00: rdata_o ← D[w].
  - 01: D[w] ← wdata, rdata_o ← wdata.
  - 10: M[w] ← wdata, rdata_o ← wdata.
  - 11: rdata_o ← nand_norn ? ~(D[w]&M[w]) : ~(D[w]|M[w]).
  - Then assert valid_o (err_o=0) and go to IDLE.
- Offset is retained between requests; no return-to-home.
- Requests while ready_o=0 are ignored. The requester must hold req_i and its operands until accepted.

## Timing
- Reset (rstn_i low at an edge):
  - State IDLE, offset 0, D and M cleared to 0.
  - valid_o=0, err_o=0, rdata_o=0, shift_cnt_o=0; shift_o=0 and shift_dir_o=0.
  - ready_o=1 from the first cycle after the reset edge.
- Reset mid-SHIFT or mid-ACCESS aborts the request: no write, no valid_o, offset returns to 0.
- Latency: valid_o is high in the cycle following the (d+2)th edge counted from the acceptance edge. Shift count is d, so with d=0 valid_o follows the 2nd edge.
- Error case: valid_o is high after the first edge.
- valid_o, err_o and rdata_o are registered. valid_o is exactly one cycle wide.
- ready_o is high in the valid_o cycle, so back-to-back acceptance is allowed.
- Throughput: at best one request per 2 cycles (d=0).
- A write followed by a read of the same word returns the new value. There is no bypass hazard because ACCESS is serialised.

## Test plan
- Reset, then read word 13 (NR=4/NB=32/NP=8, s=1):
  - One shift_o pulse with dir=1, offset_o=1.
  - valid_o follows the 3rd edge, rdata_o=0, shift_cnt_o=1.
- Write data 0xA to word 7 (s=3) from offset 1:
  - Two pulses with dir=1, offset_o=3.
  - Then read word 3 (s=3, d=0): no shift, rdata=0 (word 3 was never written).
  - Then read word 7: rdata=0xA.
- LiM:
  - Write D[5]=0xC and M[5]=0xA.
  - LiM read with nand_norn=1 gives rdata 0x7; with nand_norn=0 gives 0x1.
  - After the first request, offset stays at 1 and the later requests need 0 shifts.
- Direction down: from offset 3, read word 8 (s=0) → 3 pulses with dir=0, offset_o=0.
- addr_i=40 → valid_o and err_o after 1 edge, rdata_o=0, no shift, D and M unchanged.
- Assert rstn_i low during the 2nd SHIFT cycle of a write → offset_o=0, no valid_o, target word still reads 0, shift_cnt_o=0.
